// File: rtl/myproject_mul_arb_pkg.sv
// Shared types and the round-robin pick helper for the myproject shared-multiplier arbiter.
// The helper is used only when MUL_ARB_ROUND_ROBIN_EN is defined.
package myproject_mul_arb_pkg;

  localparam int MUL_OP_W = 13;
  localparam int MUL_P_W  = 26;
  localparam int MAX_REQ  = 16;
  localparam int RR_IDX_W = 4;

  typedef logic signed [MUL_OP_W-1:0] mul_op_t;
  typedef logic signed [MUL_P_W-1:0]  mul_p_t;

  // Unused requester slots must be zero. Wrapping modulo MAX_REQ then gives the
  // same search order as wrapping modulo NUM_REQ.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                  input logic [RR_IDX_W-1:0] last);
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = last + RR_IDX_W'(k);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/myproject_mul_arb_13s_13s_if.sv
// Requester/result bundle of the shared-multiplier arbiter, plus debug visibility of its state.
interface myproject_mul_arb_13s_13s_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import myproject_mul_arb_pkg::*;

  // Handshake rules:
  // - A beat transfers on a rising edge where valid and ready are both high.
  // - A requester holds valid and its operands until it sees ready.
  // - Valid never depends on ready.
  // - req_ready is combinational from req_valid and res_ready. It is one-hot or all zero.
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*MUL_OP_W-1:0] req_a;
  logic [NUM_REQ*MUL_OP_W-1:0] req_b;
  logic                        res_valid;
  logic                        res_ready;
  logic [MUL_P_W-1:0]          res_p;
  logic [ID_W-1:0]             res_id;
  logic [ID_W-1:0]             dbg_last_id;
  logic                        dbg_s1_valid;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_p, res_id, dbg_last_id, dbg_s1_valid
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_id, dbg_last_id, dbg_s1_valid
  );
endinterface

// File: rtl/myproject_mul_mul_13s_13s_26_1_1.sv
// Combinational signed multiplier core.
// It produces the full-width product of two signed operands.
module myproject_mul_mul_13s_13s_26_1_1 #(
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 26
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);
  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;

  assign a_ext = dout_WIDTH'($signed(din0));
  assign b_ext = dout_WIDTH'($signed(din1));
  assign dout  = a_ext * b_ext;
endmodule

// File: rtl/myproject_mul_arb_13s_13s.sv
// Shared 13s x 13s multiplier arbiter: an S1 operand register, the multiplier, and an S2 result register.
// MUL_ARB_ROUND_ROBIN_EN selects round-robin grants; without it, grants are fixed priority (lowest index wins).
module myproject_mul_arb_13s_13s
  import myproject_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                          ap_clk,
  input logic                          ap_rst_n,
  myproject_mul_arb_13s_13s_if.slave   bus
);

  logic            s1_valid;
  mul_op_t         s1_a;
  mul_op_t         s1_b;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] grant_id;
  mul_op_t         grant_a;
  mul_op_t         grant_b;
  logic            adv2;
  logic            acc;
  logic            xfer;
  logic [MUL_P_W-1:0] prod;

  assign adv2 = s1_valid && (!bus.res_valid || bus.res_ready);
  assign acc  = !s1_valid || adv2;
  // Gating with ap_rst_n keeps req_ready low during reset.
  assign xfer = ap_rst_n && acc && (|bus.req_valid);

`ifdef MUL_ARB_ROUND_ROBIN_EN
  logic [MAX_REQ-1:0]  valid_ext;
  logic [RR_IDX_W-1:0] last_ext;

  always_comb begin
    valid_ext = MAX_REQ'(bus.req_valid);
    last_ext  = RR_IDX_W'(last_id);
    grant_id  = ID_W'(rr_pick(valid_ext, last_ext));
  end
`else
  always_comb begin
    grant_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) grant_id = ID_W'(i);
    end
  end
`endif

  assign grant_a = bus.req_a[int'(grant_id)*MUL_OP_W +: MUL_OP_W];
  assign grant_b = bus.req_b[int'(grant_id)*MUL_OP_W +: MUL_OP_W];

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[grant_id] = 1'b1;
  end

  // S1 operand register and the last-grant pointer
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      last_id  <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= grant_a;
      s1_b     <= grant_b;
      s1_id    <= grant_id;
      last_id  <= grant_id;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  myproject_mul_mul_13s_13s_26_1_1 #(
    .din0_WIDTH(MUL_OP_W),
    .din1_WIDTH(MUL_OP_W),
    .dout_WIDTH(MUL_P_W)
  ) u_mul (
    .din0(s1_a),
    .din1(s1_b),
    .dout(prod)
  );

  // S2 result register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_p     <= '0;
      bus.res_id    <= '0;
    end else if (adv2) begin
      bus.res_valid <= 1'b1;
      bus.res_p     <= prod;
      bus.res_id    <= s1_id;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

  assign bus.dbg_last_id  = last_id;
  assign bus.dbg_s1_valid = s1_valid;

endmodule

// File: tb/tb_myproject_mul_arb_13s_13s.sv
// Bench for myproject_mul_arb_13s_13s: directed vectors, arbitration/backpressure/reset sequences, random soak.
// Expectations follow MUL_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_myproject_mul_arb_13s_13s;
  import myproject_mul_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + MUL_P_W;

  typedef struct {
    int idx;
    int a;
    int b;
    int exp_p;
  } vec_t;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]       exp_q[$];
  logic [NUM_REQ-1:0] pend;
  logic [12:0]        op_a[NUM_REQ];
  logic [12:0]        op_b[NUM_REQ];
  int                 model_last;
  vec_t               vecs[6];
  int                 exp_g[8];

  always #5 ap_clk = ~ap_clk;

  myproject_mul_arb_13s_13s_if #(.NUM_REQ(NUM_REQ)) bus ();

  myproject_mul_arb_13s_13s #(.NUM_REQ(NUM_REQ)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    bus.req_a[i*13 +: 13] = 13'(a);
    bus.req_b[i*13 +: 13] = 13'(b);
  endtask

  task automatic do_reset();
    ap_rst_n      = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration, straight from the policy definition.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
`ifdef MUL_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_REQ; k++) if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`else
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic drive_pend();
    bus.req_valid = pend;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*13 +: 13] = op_a[i];
      bus.req_b[i*13 +: 13] = op_b[i];
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    int           g;
    int           p;
    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got id %0d p %0d expected no product", bus.res_id, $signed(bus.res_p));
      end else begin
        e = exp_q.pop_front();
        chk("sb_id", 32'(bus.res_id), 32'(e[W-1:MUL_P_W]));
        chk("sb_p", 32'($signed(bus.res_p)), 32'($signed(e[MUL_P_W-1:0])));
      end
    end
    if (bus.req_ready != '0) begin
      chk("ready_onehot", $countones(bus.req_ready), 1);
      chk("ready_legal", 32'(bus.req_ready & ~bus.req_valid), 0);
      g = onehot_idx(bus.req_ready);
      chk("grant", g, model_pick(bus.req_valid, model_last));
      model_last = g;
      pend[g]    = 1'b0;
      p = int'($signed(op_a[g])) * int'($signed(op_b[g]));
      exp_q.push_back({ID_W'(g), MUL_P_W'(p)});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{idx: 1, a: 100,   b: -3,    exp_p: -300};
    vecs[1] = '{idx: 0, a: -4096, b: -4096, exp_p: 16777216};
    vecs[2] = '{idx: 0, a: 4095,  b: -4096, exp_p: -16773120};
    vecs[3] = '{idx: 3, a: -1,    b: -1,    exp_p: 1};
    vecs[4] = '{idx: 2, a: 0,     b: 5,     exp_p: 0};
    vecs[5] = '{idx: 3, a: 4095,  b: 4095,  exp_p: 16769025};
`ifdef MUL_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    exp_g = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset state, with every requester valid to show req_ready is gated.
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    #1 ap_rst_n = 1'b0;
    #2;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_p", 32'(bus.res_p), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_last_id", 32'(bus.dbg_last_id), NUM_REQ - 1);
    chk("rst_s1_valid", 32'(bus.dbg_s1_valid), 0);
    do_reset();

    // Directed single-request vectors: 2-cycle latency, one-cycle result pulse.
    foreach (vecs[v]) begin
      @(negedge ap_clk);
      bus.req_valid = NUM_REQ'(1 << vecs[v].idx);
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      bus.res_ready = 1'b1;
      #1 chk("vec_ready", 32'(bus.req_ready), 1 << vecs[v].idx);
      @(negedge ap_clk);
      bus.req_valid = '0;
      #1 chk("vec_s2_empty", 32'(bus.res_valid), 0);
      @(negedge ap_clk);
      #1;
      chk("vec_valid", 32'(bus.res_valid), 1);
      chk("vec_p", 32'($signed(bus.res_p)), vecs[v].exp_p);
      chk("vec_id", 32'(bus.res_id), vecs[v].idx);
      @(negedge ap_clk);
      #1 chk("vec_pulse", 32'(bus.res_valid), 0);
    end

    // All requesters valid for 8 cycles, starting from the reset pointer.
    @(negedge ap_clk);
    do_reset();
    for (int j = 0; j < 10; j++) begin
      @(negedge ap_clk);
      bus.req_valid = (j < 8) ? 4'hF : 4'h0;
      bus.res_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, i + 1, 2);
      #1;
      if (j < 8) chk("rr_grant", onehot_idx(bus.req_ready), exp_g[j]);
      if (j >= 2) chk("rr_res_id", 32'(bus.res_id), exp_g[j-2]);
    end

    // Backpressure: both stages fill, then drain in order.
    @(negedge ap_clk);
    do_reset();
    @(negedge ap_clk);
    bus.req_valid = 4'b0100;
    set_ops(2, 7, 9);
    bus.res_ready = 1'b0;
    #1 chk("bp_ready0", 32'(bus.req_ready), 4);
    @(negedge ap_clk);
    set_ops(2, 11, 13);
    #1 chk("bp_ready1", 32'(bus.req_ready), 4);
    @(negedge ap_clk);
    set_ops(2, -5, 6);
    #1;
    chk("bp_full_valid", 32'(bus.res_valid), 1);
    chk("bp_full_ready", 32'(bus.req_ready), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      #1;
      chk("bp_hold_ready", 32'(bus.req_ready), 0);
      chk("bp_hold_p", 32'($signed(bus.res_p)), 63);
      chk("bp_hold_id", 32'(bus.res_id), 2);
    end
    @(negedge ap_clk);
    bus.res_ready = 1'b1;
    #1;
    chk("bp_drain0_p", 32'($signed(bus.res_p)), 63);
    chk("bp_drain0_ready", 32'(bus.req_ready), 4);
    @(negedge ap_clk);
    bus.req_valid = '0;
    #1;
    chk("bp_drain1_valid", 32'(bus.res_valid), 1);
    chk("bp_drain1_p", 32'($signed(bus.res_p)), 143);
    @(negedge ap_clk);
    #1;
    chk("bp_drain2_valid", 32'(bus.res_valid), 1);
    chk("bp_drain2_p", 32'($signed(bus.res_p)), -30);
    @(negedge ap_clk);
    #1 chk("bp_empty", 32'(bus.res_valid), 0);

    // Asynchronous reset with both stages full.
    @(negedge ap_clk);
    do_reset();
    @(negedge ap_clk);
    bus.req_valid = 4'b0100;
    set_ops(2, 3, 3);
    bus.res_ready = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    #1 chk("mid_full", 32'(bus.dbg_s1_valid && bus.res_valid), 1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("mid_res_valid", 32'(bus.res_valid), 0);
    chk("mid_req_ready", 32'(bus.req_ready), 0);
    chk("mid_s1_valid", 32'(bus.dbg_s1_valid), 0);
    @(negedge ap_clk);
    ap_rst_n      = 1'b1;
    bus.req_valid = 4'b1010;
    bus.res_ready = 1'b1;
    #1 chk("mid_first_grant", 32'(bus.req_ready), 4'b0010);

    // Random soak against the scoreboard.
    @(negedge ap_clk);
    do_reset();
    model_last = NUM_REQ - 1;
    pend       = '0;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge ap_clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op_a[i] = ($urandom_range(0, 15) == 0) ? 13'h1000 : 13'($urandom);
          op_b[i] = ($urandom_range(0, 15) == 0) ? 13'h1000 : 13'($urandom);
        end
      end
      drive_pend();
      bus.res_ready = ($urandom_range(0, 3) != 0);
      #1 monitor();
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge ap_clk);
      drive_pend();
      bus.res_ready = 1'b1;
      #1 monitor();
    end
    chk("drain_pending", 32'(pend), 0);
    chk("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
